// File: rtl/monitor_pkg.sv
// Shared run-control types: monitor states, halt causes and default exception bit indices.
// Used by run_monitor, the seven-segment display and the CPU.
package monitor_pkg;

   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_RUN   = 3'd1,
      ST_HALT  = 3'd2,
      ST_ERROR = 3'd3,
      ST_STEP  = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      CAUSE_NONE   = 4'd0,
      CAUSE_ERR    = 4'd1,
      CAUSE_EBREAK = 4'd2,
      CAUSE_ECALL  = 4'd3,
      CAUSE_REQ    = 4'd4,
      CAUSE_STEP   = 4'd5,
      CAUSE_WDT    = 4'd6
   } cause_e;

   localparam logic [7:0]  DEF_ERR_MASK   = 8'h07;
   localparam int unsigned DEF_ECALL_BIT  = 3;
   localparam int unsigned DEF_EBREAK_BIT = 4;

   // RUN and STEP are the only states in which instructions may retire.
   function automatic logic is_active(state_e s);
      return (s == ST_RUN) || (s == ST_STEP);
   endfunction

endpackage

// File: rtl/run_monitor_cnt.sv
// Free-running up-counter with enable and synchronous clear; wraps modulo 2^W.
module run_monitor_cnt #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/run_monitor.sv
// Run-control monitor: PC commit gating, exception classification, host halt/resume/step,
// cycle/instret counters. Optional stall watchdog enabled by defining RUN_MONITOR_WDT_EN.
module run_monitor
   import monitor_pkg::*;
#(
   parameter int unsigned          EXC_WIDTH  = 8,
   parameter logic [EXC_WIDTH-1:0] ERR_MASK   = EXC_WIDTH'(DEF_ERR_MASK),
   parameter int unsigned          ECALL_BIT  = DEF_ECALL_BIT,
   parameter int unsigned          EBREAK_BIT = DEF_EBREAK_BIT,
   parameter bit                   ECALL_TRAP = 1'b0,
   parameter int unsigned          CNT_WIDTH  = 64,
   parameter int unsigned          WDT_LIMIT  = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [EXC_WIDTH-1:0] exceptions_i,
   input  logic                 stall_i,
   input  logic                 halt_req_i,
   input  logic                 resume_i,
   input  logic                 step_i,
   input  logic                 clear_i,
   output logic                 pc_we_o,
   output logic                 trap_o,
   output logic [2:0]           state_o,
   output logic [2:0]           nstate_o,
   output logic [3:0]           cause_o,
   output logic [CNT_WIDTH-1:0] cycle_o,
   output logic [CNT_WIDTH-1:0] instret_o
);

   state_e state, nstate;
   cause_e cause, ncause;
   logic   active, err, ebk, ecl, ecl_halt, wdt_fire;

   assign active   = is_active(state);
   assign err      = |(exceptions_i & ERR_MASK);
   assign ebk      = exceptions_i[EBREAK_BIT];
   assign ecl      = exceptions_i[ECALL_BIT];
   assign ecl_halt = ecl && !ECALL_TRAP;

   // A faulting or halting instruction never commits; a trapping ECALL commits the redirect.
   assign pc_we_o = active && !stall_i && !err && !ebk && !ecl_halt;
   assign trap_o  = active && !stall_i && ecl && ECALL_TRAP && !err && !ebk;

`ifdef RUN_MONITOR_WDT_EN
   localparam int unsigned WDT_W = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;
   logic [WDT_W-1:0] wdt_cnt;
   logic             wdt_run;

   assign wdt_run  = active && stall_i;
   assign wdt_fire = wdt_run && (wdt_cnt == WDT_W'(WDT_LIMIT - 1));

   run_monitor_cnt #(.W(WDT_W)) u_wdt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (!wdt_run),
      .en    (wdt_run),
      .count (wdt_cnt)
   );
`else
   assign wdt_fire = 1'b0;
`endif

   always_comb begin
      nstate = state;
      ncause = cause;
      case (state)
         ST_RST: nstate = halt_req_i ? ST_HALT : ST_RUN;
         ST_RUN, ST_STEP: begin
            if (err) begin
               nstate = ST_ERROR;
               ncause = CAUSE_ERR;
            end else if (ebk) begin
               nstate = ST_HALT;
               ncause = CAUSE_EBREAK;
            end else if (ecl_halt) begin
               nstate = ST_HALT;
               ncause = CAUSE_ECALL;
            end else if (wdt_fire) begin
               nstate = ST_ERROR;
               ncause = CAUSE_WDT;
            end else if (state == ST_RUN && halt_req_i) begin
               nstate = ST_HALT;
               ncause = CAUSE_REQ;
            end else if (state == ST_STEP && pc_we_o) begin
               nstate = ST_HALT;
               ncause = CAUSE_STEP;
            end
         end
         ST_HALT: begin
            if (resume_i) begin
               nstate = ST_RUN;
               ncause = CAUSE_NONE;
            end else if (step_i) begin
               nstate = ST_STEP;
            end
         end
         ST_ERROR: if (clear_i) nstate = ST_HALT;
         default:  nstate = ST_RST;
      endcase
      if (rst_i) begin
         nstate = ST_RST;
         ncause = CAUSE_NONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_RST;
         cause <= CAUSE_NONE;
      end else begin
         state <= nstate;
         cause <= ncause;
      end
   end

   run_monitor_cnt #(.W(CNT_WIDTH)) u_cycle (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (1'b0),
      .en    (active),
      .count (cycle_o)
   );

   run_monitor_cnt #(.W(CNT_WIDTH)) u_instret (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (1'b0),
      .en    (pc_we_o),
      .count (instret_o)
   );

   assign state_o  = state;
   assign nstate_o = nstate;
   assign cause_o  = cause;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: two instances (ECALL halts with 64-bit counters, ECALL traps with
// 4-bit counters) driven in lockstep and compared each cycle against a behavioural model.
module tb_run_monitor;
   localparam int WDT_LIMIT = 8;
`ifdef RUN_MONITOR_WDT_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] exc = '0;
   logic       stall = 1'b0, halt_req = 1'b0, resume = 1'b0, step = 1'b0, clear = 1'b0;

   logic        a_we, a_trap, b_we, b_trap;
   logic [2:0]  a_state, a_nstate, b_state, b_nstate;
   logic [3:0]  a_cause, b_cause, b_cyc, b_ins;
   logic [63:0] a_cyc, a_ins;

   always #5 clk = ~clk;

   run_monitor #(.WDT_LIMIT(WDT_LIMIT)) u_halt (
      .clk_i(clk), .rst_i(rst), .exceptions_i(exc), .stall_i(stall), .halt_req_i(halt_req),
      .resume_i(resume), .step_i(step), .clear_i(clear), .pc_we_o(a_we), .trap_o(a_trap),
      .state_o(a_state), .nstate_o(a_nstate), .cause_o(a_cause), .cycle_o(a_cyc), .instret_o(a_ins)
   );

   run_monitor #(.ECALL_TRAP(1'b1), .CNT_WIDTH(4), .WDT_LIMIT(WDT_LIMIT)) u_trap (
      .clk_i(clk), .rst_i(rst), .exceptions_i(exc), .stall_i(stall), .halt_req_i(halt_req),
      .resume_i(resume), .step_i(step), .clear_i(clear), .pc_we_o(b_we), .trap_o(b_trap),
      .state_o(b_state), .nstate_o(b_nstate), .cause_o(b_cause), .cycle_o(b_cyc), .instret_o(b_ins)
   );

   logic [63:0] o_we[2], o_trap[2], o_st[2], o_ns[2], o_ca[2], o_cy[2], o_in[2];
   assign o_we[0] = 64'(a_we);     assign o_we[1] = 64'(b_we);
   assign o_trap[0] = 64'(a_trap); assign o_trap[1] = 64'(b_trap);
   assign o_st[0] = 64'(a_state);  assign o_st[1] = 64'(b_state);
   assign o_ns[0] = 64'(a_nstate); assign o_ns[1] = 64'(b_nstate);
   assign o_ca[0] = 64'(a_cause);  assign o_ca[1] = 64'(b_cause);
   assign o_cy[0] = a_cyc;         assign o_cy[1] = 64'(b_cyc);
   assign o_in[0] = a_ins;         assign o_in[1] = 64'(b_ins);

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_no, got, exp);
      end
   endtask

   // Reference model. States: 0 RST, 1 RUN, 2 HALT, 3 ERROR, 4 STEP.
   // Causes: 0 NONE, 1 ERR, 2 EBREAK, 3 ECALL, 4 REQ, 5 STEP, 6 WDT.
   int              m_state[2], m_cause[2], m_stalls[2];
   longint unsigned m_cyc[2], m_ins[2];
   bit              p_we[2], p_trap[2];
   int              p_ns[2], p_nc[2];

   function automatic bit traps(int k);
      return k == 1;
   endfunction

   function automatic longint unsigned wrap(int k, longint unsigned v);
      return (k == 1) ? (v % 16) : v;
   endfunction

   function automatic bit running(int k);
      return m_state[k] == 1 || m_state[k] == 4;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = 0; m_cause[k] = 0; m_stalls[k] = 0;
         m_cyc[k] = 0;   m_ins[k] = 0;
      end
   endtask

   task automatic predict(input int k);
      bit fatal, brk, call, halts_on_call, dog, go;
      fatal = (exc & 8'h07) != 0;
      brk   = exc[4];
      call  = exc[3];
      halts_on_call = call && !traps(k);
      go    = running(k) && !stall;
      p_we[k]   = go && !fatal && !brk && !halts_on_call;
      p_trap[k] = go && call && traps(k) && !fatal && !brk;
      dog  = WDT_ON && running(k) && stall && (m_stalls[k] == WDT_LIMIT - 1);
      p_ns[k] = m_state[k];
      p_nc[k] = m_cause[k];
      if (rst) begin
         p_ns[k] = 0; p_nc[k] = 0;
      end else if (m_state[k] == 0) begin
         p_ns[k] = halt_req ? 2 : 1;
      end else if (running(k)) begin
         if (fatal)                          begin p_ns[k] = 3; p_nc[k] = 1; end
         else if (brk)                       begin p_ns[k] = 2; p_nc[k] = 2; end
         else if (halts_on_call)             begin p_ns[k] = 2; p_nc[k] = 3; end
         else if (dog)                       begin p_ns[k] = 3; p_nc[k] = 6; end
         else if (m_state[k] == 1 && halt_req) begin p_ns[k] = 2; p_nc[k] = 4; end
         else if (m_state[k] == 4 && p_we[k])  begin p_ns[k] = 2; p_nc[k] = 5; end
      end else if (m_state[k] == 2) begin
         if (resume)    begin p_ns[k] = 1; p_nc[k] = 0; end
         else if (step) p_ns[k] = 4;
      end else if (m_state[k] == 3) begin
         if (clear) p_ns[k] = 2;
      end
   endtask

   task automatic advance(input int k);
      if (rst) begin
         m_state[k] = 0; m_cause[k] = 0; m_stalls[k] = 0; m_cyc[k] = 0; m_ins[k] = 0;
      end else begin
         if (running(k)) m_cyc[k] = wrap(k, m_cyc[k] + 1);
         if (p_we[k])    m_ins[k] = wrap(k, m_ins[k] + 1);
         m_stalls[k] = (running(k) && stall) ? m_stalls[k] + 1 : 0;
         m_state[k]  = p_ns[k];
         m_cause[k]  = p_nc[k];
      end
   endtask

   // Inputs are set 1ns after a rising edge; outputs are checked 1ns later.
   task automatic tick();
      string nm;
      #1;
      for (int k = 0; k < 2; k++) begin
         nm = (k == 0) ? "halt" : "trap";
         predict(k);
         check({nm, ".state"},   o_st[k], 64'(m_state[k]));
         check({nm, ".cause"},   o_ca[k], 64'(m_cause[k]));
         check({nm, ".cycle"},   o_cy[k], m_cyc[k]);
         check({nm, ".instret"}, o_in[k], m_ins[k]);
         if (!rst) begin
            check({nm, ".pc_we"},  o_we[k],   64'(p_we[k]));
            check({nm, ".trap"},   o_trap[k], 64'(p_trap[k]));
            check({nm, ".nstate"}, o_ns[k],   64'(p_ns[k]));
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) advance(k);
      cyc_no++;
      #1;
   endtask

   task automatic drive(input logic [7:0] e, input logic s, input logic h,
                        input logic r, input logic st, input logic c);
      exc = e; stall = s; halt_req = h; resume = r; step = st; clear = c;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      @(posedge clk);
      #1;
      model_reset();
      tick();
      rst = 1'b0;

      // RST cycle, then ten clean RUN cycles.
      idle(11);
      // EBREAK halts without commit; resume continues the counters.
      drive(8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      // ECALL: halt instance stops with cause ECALL, trap instance redirects and keeps running.
      drive(8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      // Host halt, then a single step with three stalled cycles.
      drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      // Fatal exception: ERROR is sticky against resume and exceptions, left with clear.
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(1);
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // Resume and step together: resume wins. Then a long stall in RUN.
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < WDT_LIMIT + 4; i++) drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      // Reset asserted mid-run, then released with halt request held.
      rst = 1'b1;
      drive(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] e;
         e = 8'h00;
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 4))
               0: e = 8'h08;
               1: e = 8'h10;
               2: e = 8'h18;
               3: e = 8'(1 << $urandom_range(0, 2));
               default: e = 8'($urandom_range(0, 255));
            endcase
         end
         rst = ($urandom_range(0, 299) == 0);
         drive(e,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 9) == 0);
      end
      rst = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_monitor.md
# run_monitor

Parametrised run-control monitor for the single-cycle RV64I core: decides each cycle whether the PC register commits, classifies CPU exception flags into halt, trap-redirect or error, and supports host-driven halt / resume / single-step. Keeps cycle and retired-instruction counters, registers the halt cause for the seven-segment display, and optionally runs a stall watchdog. Sits between the CPU exception vector, the PC register write-enable and the display.

## Interface
- EXC_WIDTH, 8: width of the CPU exception vector.
- ERR_MASK, 8'h07: exception bits that are fatal (fetch, decode, anomaly).
- ECALL_BIT, 3: exception bit index for ECALL.
- EBREAK_BIT, 4: exception bit index for EBREAK.
- ECALL_TRAP, 0: 0 = ECALL halts; 1 = ECALL pulses a trap redirect and execution continues.
- CNT_WIDTH, 64: cycle / instret counter width.
- WDT_LIMIT, 1024: consecutive stall cycles that trigger the watchdog.

- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- exceptions_i  in  EXC_WIDTH  CPU exception flags for the current instruction.
- stall_i  in  1  CPU cannot retire this cycle (multi-cycle memory).
- halt_req_i  in  1  host halt request, level.
- resume_i  in  1  host resume, single-cycle pulse.
- step_i  in  1  host single-step, single-cycle pulse.
- clear_i  in  1  leave ERROR and return to HALT.
- pc_we_o  out  1  PC register write-enable, combinational.
- trap_o  out  1  trap redirect pulse; PC loads the trap vector.
- state_o  out  3  current state; nstate_o  out  3  next state, for the display.
- cause_o  out  4  registered halt/error cause.
- cycle_o  out  CNT_WIDTH  cycles spent in RUN or STEP.
- instret_o  out  CNT_WIDTH  retired-instruction count.

## Operation
- States: RST=0, RUN=1, HALT=2, ERROR=3, STEP=4. Cause codes: NONE=0, ERR=1, EBREAK=2, ECALL=3, REQ=4, STEP=5, WDT=6.
- err = |(exceptions_i & ERR_MASK); ebk = exceptions_i[EBREAK_BIT]; ecl = exceptions_i[ECALL_BIT].
- pc_we_o = (state is RUN or STEP) & !stall_i & !err & !ebk & !(ecl & !ECALL_TRAP). The faulting or halting instruction never commits.
- trap_o = (state is RUN or STEP) & !stall_i & ecl & ECALL_TRAP & !err & !ebk. pc_we_o is also high in that cycle.
- RST -> HALT if halt_req_i, else RUN.
- RUN and STEP transitions, checked in priority order:
  - err -> ERROR, cause ERR.
  - ebk -> HALT, cause EBREAK.
  - ecl with ECALL_TRAP=0 -> HALT, cause ECALL.
  - watchdog fire -> ERROR, cause WDT.
  - RUN only: halt_req_i -> HALT, cause REQ. The current instruction still commits.
  - STEP only: a retire (pc_we_o) -> HALT, cause STEP.
  - Otherwise stay in the current state.
- HALT: resume_i -> RUN, cause NONE. Otherwise step_i -> STEP. resume_i wins when both are high.
- ERROR: sticky. clear_i -> HALT, cause keeps its value. Exception inputs are ignored.
- Counters: cycle_o increments in RUN and STEP. instret_o increments on pc_we_o. Both wrap modulo 2^CNT_WIDTH.

## Timing
- On rst_i: state RST, cause NONE, both counters 0, watchdog 0.
- Reset-state outputs: pc_we_o=0, trap_o=0, nstate_o=RUN (or HALT while halt_req_i is high).
- rst_i asserted mid-run overrides every input in that cycle. This is the only way out of ERROR besides clear_i.
- state_o and cause_o update one cycle after the deciding inputs.
- pc_we_o and trap_o are same-cycle combinational; no input-to-commit latency.
- Step latency: step_i in cycle N -> STEP in N+1; first unstalled cycle retires; HALT on the following edge.
- Host pulses arriving while in RUN or ERROR are ignored.

## Configuration
- RUN_MONITOR_WDT_EN defined: a counter of consecutive cycles with stall_i high in RUN or STEP.
  - It clears on any cycle without a stall and whenever the state is not RUN or STEP.
  - When it reaches WDT_LIMIT-1 while stall_i is still high, it fires: next state ERROR, cause WDT.
- RUN_MONITOR_WDT_EN undefined: no watchdog logic; cause WDT is never produced.

## Structure
- Package monitor_pkg: state enum, cause enum, and default exception bit indices, shared with Display and the CPU.
- Sub-module run_monitor_cnt: a parametrised CNT_WIDTH counter with enable and synchronous clear, instanced twice (cycle, instret). The watchdog reuses it at $clog2(WDT_LIMIT) width.

## Test plan
- Reset, then 10 clean cycles -> state RUN, pc_we_o=1 for all 10, instret_o=10, cycle_o=10.
- exceptions_i=8'h10 in RUN -> pc_we_o=0 that cycle; next state HALT, cause 2. Then resume_i -> RUN, and instret_o resumes from its held value.
- ECALL_TRAP=1 and exceptions_i=8'h08 -> trap_o=1 and pc_we_o=1 that cycle; state stays RUN. With ECALL_TRAP=0 -> HALT, cause 3.
- In HALT, pulse step_i with stall_i high for 3 cycles -> STEP for 4 cycles; instret_o rises by exactly 1; then HALT, cause 5.
- exceptions_i=8'h04 -> ERROR, cause 1. resume_i has no effect; clear_i -> HALT.
- With RUN_MONITOR_WDT_EN and WDT_LIMIT=8, hold stall_i high in RUN -> ERROR, cause 6, on the 8th stall cycle's edge.
